// File: rtl/codec_i2c_master_pkg.sv
// rtl/codec_i2c_master_pkg.sv - shared constants, FSM states and SCL/SDA level table
// Purpose : constants used by the WM8731 write-only I2C master and its bench:
//           FSM state encodings, default quarter-period divider, device address,
//           and the per-quarter SCL/SDA drive levels of each bus phase.
// Ports   : none (package).
// Config  : none here; optional ACK checking lives in codec_i2c_master.sv.
package codec_i2c_master_pkg;

    localparam int         I2C_CLK_DIV     = 125;    // 50 MHz / (4*125) = 100 kHz SCL
    localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;  // CSB low, write bit included

    typedef enum logic [2:0] {
        I2C_ST_IDLE,
        I2C_ST_START,
        I2C_ST_BIT,
        I2C_ST_ACK,
        I2C_ST_STOP
    } i2c_state_t;

    typedef struct packed {
        logic scl;
        logic sda_oe;
    } i2c_drive_t;

    // Bus levels held for the whole of quarter q of a given phase.
    // SCL is low in q0,q1 and high in q2,q3 of data/ACK slots, so SDA only
    // ever moves while SCL is low except for START (q2) and STOP (q2).
    function automatic i2c_drive_t i2c_levels(input i2c_state_t st,
                                              input logic [1:0] q,
                                              input logic       bit_val);
        i2c_drive_t d;
        d.scl    = 1'b1;
        d.sda_oe = 1'b0;
        case (st)
            I2C_ST_START: begin
                d.scl    = (q != 2'd3);
                d.sda_oe = q[1];
            end
            I2C_ST_BIT: begin
                d.scl    = q[1];
                d.sda_oe = ~bit_val;
            end
            I2C_ST_ACK: begin
                d.scl    = q[1];
                d.sda_oe = 1'b0;
            end
            I2C_ST_STOP: begin
                d.scl    = (q != 2'd0);
                d.sda_oe = ~q[1];
            end
            default: begin
                d.scl    = 1'b1;
                d.sda_oe = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/codec_i2c_master_if.sv
// rtl/codec_i2c_master_if.sv - packet handshake and I2C pin bundle
// Purpose : groups the upstream packet strobe and the I2C pins of the codec master.
// Signals : i2c_packet[23:0], wr_i2c (upstream -> master), i2c_idle (master -> upstream),
//           i2c_sclk, i2c_sda_oe (master -> pins), i2c_sda_i (pin -> master),
//           ack_error (sticky NACK flag).
// Modports: master = the I2C master, slave = upstream driver plus pin/codec side.
interface codec_i2c_master_if;

    logic [23:0] i2c_packet;
    logic        wr_i2c;
    logic        i2c_idle;
    logic        i2c_sclk;
    logic        i2c_sda_oe;
    logic        i2c_sda_i;
    logic        ack_error;

    modport master (
        input  i2c_packet, wr_i2c, i2c_sda_i,
        output i2c_idle, i2c_sclk, i2c_sda_oe, ack_error
    );

    modport slave (
        output i2c_packet, wr_i2c, i2c_sda_i,
        input  i2c_idle, i2c_sclk, i2c_sda_oe, ack_error
    );

endinterface

// File: rtl/codec_i2c_clkgen.sv
// rtl/codec_i2c_clkgen.sv - quarter-SCL-period tick generator
// Purpose : while enabled, counts Clk cycles 0..CLK_DIV-1 and pulses tick on the
//           terminal count; quarter is the index (0..3) of the running quarter.
//           Disabling clears both counters so every transfer starts at q0.
// Ports   : Clk, Rst_n (async active-low), enable in; tick, quarter[1:0] out.
module codec_i2c_clkgen #(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == TERM);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt     <= '0;
            quarter <= 2'd0;
        end else if (!enable) begin
            cnt     <= '0;
            quarter <= 2'd0;
        end else if (cnt == TERM) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/codec_i2c_master.sv
// rtl/codec_i2c_master.sv - write-only I2C master for the WM8731 control port
// Purpose : serialises a 24-bit packet as START, 3 bytes MSB-first each followed
//           by an ACK slot, then STOP. i2c_idle=1 means a new packet is accepted.
// Ports   : Clk, Rst_n (async active-low); bus (codec_i2c_master_if.master):
//           i2c_packet, wr_i2c in; i2c_idle out; i2c_sclk, i2c_sda_oe out;
//           i2c_sda_i in (asynchronous pin); ack_error out.
// Config  : CODEC_I2C_ACK_CHECK_EN - sample ACK slots, flag NACK in ack_error
//           and cut the transfer short with STOP. Undefined: ack_error tied 0.
module codec_i2c_master
    import codec_i2c_master_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV,
    parameter int CNT_W   = 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    codec_i2c_master_if.master      bus
);

    i2c_state_t  state;
    logic [23:0] shift_reg;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic        idle_q;
    i2c_drive_t  drive_q;
    logic        tick;
    logic [1:0]  quarter;
    logic        ack_stop;

    codec_i2c_clkgen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_clkgen (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .enable  (state != I2C_ST_IDLE),
        .tick    (tick),
        .quarter (quarter)
    );

`ifdef CODEC_I2C_ACK_CHECK_EN
    logic [1:0] sda_sync;
    logic       nack_q;
    logic       ack_err_q;

    // SDA comes straight from the pad; resynchronise before sampling ACK.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) sda_sync <= 2'b11;
        else        sda_sync <= {sda_sync[0], bus.i2c_sda_i};
    end

    assign ack_stop      = nack_q;
    assign bus.ack_error = ack_err_q;
`else
    assign ack_stop      = 1'b0;
    assign bus.ack_error = 1'b0;
`endif

    assign bus.i2c_idle   = idle_q;
    assign bus.i2c_sclk   = drive_q.scl;
    assign bus.i2c_sda_oe = drive_q.sda_oe;

    // Outputs are registered one quarter ahead: on each tick the levels for the
    // quarter that starts next are loaded, so pins change exactly at quarter start.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= I2C_ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            idle_q    <= 1'b1;
            drive_q   <= i2c_levels(I2C_ST_IDLE, 2'd0, 1'b0);
`ifdef CODEC_I2C_ACK_CHECK_EN
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
`endif
        end else if (state == I2C_ST_IDLE) begin
            // START q0 has the same levels as idle, so drive_q needs no update.
            if (bus.wr_i2c) begin
                shift_reg <= bus.i2c_packet;
                bit_cnt   <= 3'd0;
                byte_cnt  <= 2'd0;
                idle_q    <= 1'b0;
                state     <= I2C_ST_START;
`ifdef CODEC_I2C_ACK_CHECK_EN
                nack_q    <= 1'b0;
                ack_err_q <= 1'b0;
`endif
            end
        end else if (tick) begin
            if (quarter != 2'd3) begin
                drive_q <= i2c_levels(state, quarter + 2'd1, shift_reg[23]);
`ifdef CODEC_I2C_ACK_CHECK_EN
                // End of q2 is mid SCL-high, where the slave's ACK is stable.
                if (state == I2C_ST_ACK && quarter == 2'd2) begin
                    nack_q <= sda_sync[1];
                    if (sda_sync[1]) ack_err_q <= 1'b1;
                end
`endif
            end else begin
                case (state)
                    I2C_ST_START: begin
                        state   <= I2C_ST_BIT;
                        drive_q <= i2c_levels(I2C_ST_BIT, 2'd0, shift_reg[23]);
                    end
                    I2C_ST_BIT: begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            state   <= I2C_ST_ACK;
                            drive_q <= i2c_levels(I2C_ST_ACK, 2'd0, 1'b0);
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            drive_q <= i2c_levels(I2C_ST_BIT, 2'd0, shift_reg[22]);
                        end
                    end
                    I2C_ST_ACK: begin
                        if (byte_cnt == 2'd2 || ack_stop) begin
                            state   <= I2C_ST_STOP;
                            drive_q <= i2c_levels(I2C_ST_STOP, 2'd0, 1'b0);
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= I2C_ST_BIT;
                            drive_q  <= i2c_levels(I2C_ST_BIT, 2'd0, shift_reg[23]);
                        end
                    end
                    default: begin
                        state   <= I2C_ST_IDLE;
                        idle_q  <= 1'b1;
                        drive_q <= i2c_levels(I2C_ST_IDLE, 2'd0, 1'b0);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_codec_i2c_master.sv
// tb/tb_codec_i2c_master.sv - directed bench for codec_i2c_master with an I2C slave model
module tb_codec_i2c_master;
    import codec_i2c_master_pkg::*;

    localparam int DIV     = 4;
    localparam int LEN_OK  = 116 * DIV;      // 464 cycles, +1 allowed
    localparam int LEN_NAK = (4 + 9*4 + 4) * DIV;  // START, byte 1 + ACK, STOP

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    codec_i2c_master_if bus();

    codec_i2c_master #(
        .CLK_DIV (DIV),
        .CNT_W   (8)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.master)
    );

    // ---------------- slave model on the open-drain SDA line ----------------
    logic       slave_pull = 1'b0;
    int         nack_idx   = -1;
    logic       prev_scl   = 1'b1;
    logic       prev_sda   = 1'b1;
    logic [7:0] m_sh       = 8'h00;
    int         m_bits     = 0;
    int         rx_cnt     = 0;
    int         start_cnt  = 0;
    int         stop_cnt   = 0;
    logic [7:0] rx_byte [0:2];
    logic       sda_now;

    assign sda_now       = ~(bus.i2c_sda_oe | slave_pull);
    assign bus.i2c_sda_i = sda_now;

    always @(negedge Clk) begin
        prev_scl <= bus.i2c_sclk;
        prev_sda <= sda_now;
        if (!Rst_n) begin
            slave_pull <= 1'b0;
        end else if (prev_scl && bus.i2c_sclk && prev_sda && !sda_now) begin
            start_cnt <= start_cnt + 1;
            m_bits    <= 0;
            rx_cnt    <= 0;
        end else if (prev_scl && bus.i2c_sclk && !prev_sda && sda_now) begin
            stop_cnt <= stop_cnt + 1;
        end else if (!prev_scl && bus.i2c_sclk) begin
            if (m_bits == 8) begin
                m_bits <= 0;
            end else begin
                m_sh   <= {m_sh[6:0], sda_now};
                m_bits <= m_bits + 1;
                if (m_bits == 7 && rx_cnt < 3) begin
                    rx_byte[rx_cnt] <= {m_sh[6:0], sda_now};
                    rx_cnt          <= rx_cnt + 1;
                end
            end
        end else if (prev_scl && !bus.i2c_sclk) begin
            slave_pull <= (m_bits == 8) && ((rx_cnt - 1) != nack_idx);
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe a packet and return cycles from the wr_i2c cycle to i2c_idle=1.
    // now=1 drives the strobe in the current negedge (back-to-back case).
    task automatic run_pkt(input logic [23:0] pkt, input bit now, input int poke_at,
                           input logic [23:0] poke_pkt, output int cyc);
        if (!now) @(negedge Clk);
        bus.wr_i2c     = 1'b1;
        bus.i2c_packet = pkt;
        @(negedge Clk);
        bus.wr_i2c = 1'b0;
        cyc = 1;
        while (!bus.i2c_idle && cyc < 2000) begin
            if (cyc == poke_at) begin
                bus.wr_i2c     = 1'b1;
                bus.i2c_packet = poke_pkt;
            end else if (cyc == poke_at + 1) begin
                bus.wr_i2c = 1'b0;
            end
            @(negedge Clk);
            cyc++;
        end
    endtask

    int cyc, s0, p0, bad_idle, bad_scl, bad_oe;

    task automatic chk_full(input string tag, input int c, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        chk({tag, "_len"},   (c >= LEN_OK && c <= LEN_OK + 1), 1);
        chk({tag, "_nbyte"}, rx_cnt, 3);
        chk({tag, "_b0"},    rx_byte[0], b0);
        chk({tag, "_b1"},    rx_byte[1], b1);
        chk({tag, "_b2"},    rx_byte[2], b2);
        chk({tag, "_start"}, start_cnt - s0, 1);
        chk({tag, "_stop"},  stop_cnt - p0, 1);
        chk({tag, "_ackerr"}, bus.ack_error, 0);
    endtask

    initial begin
        Rst_n          = 1'b0;
        bus.wr_i2c     = 1'b0;
        bus.i2c_packet = '0;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_idle", bus.i2c_idle, 1);
        chk("rst_scl",  bus.i2c_sclk, 1);
        chk("rst_oe",   bus.i2c_sda_oe, 0);
        chk("rst_ackerr", bus.ack_error, 0);

        // 1: quiet bus with no strobe
        bad_idle = 0; bad_scl = 0; bad_oe = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (bus.i2c_idle !== 1'b1)   bad_idle++;
            if (bus.i2c_sclk !== 1'b1)   bad_scl++;
            if (bus.i2c_sda_oe !== 1'b0) bad_oe++;
        end
        chk("t1_idle_bad", bad_idle, 0);
        chk("t1_scl_bad",  bad_scl, 0);
        chk("t1_oe_bad",   bad_oe, 0);
        chk("t1_no_start", start_cnt, 0);

        // 2: codec reset register write
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt({WM8731_DEV_ADDR, 16'h1E00}, 1'b0, -5, 24'h0, cyc);
        chk_full("t2", cyc, 8'h34, 8'h1E, 8'h00);

        // 3: strobe while busy must be ignored
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt(24'h341E00, 1'b0, 100, 24'h340C00, cyc);
        chk_full("t3", cyc, 8'h34, 8'h1E, 8'h00);
        repeat (60) @(negedge Clk);
        chk("t3_no_restart", start_cnt - s0, 1);
        chk("t3_still_idle", bus.i2c_idle, 1);

        // 4: asynchronous reset in the middle of byte 2 (quarter 55)
        @(negedge Clk);
        bus.wr_i2c = 1'b1; bus.i2c_packet = 24'h341E00;
        @(negedge Clk);
        bus.wr_i2c = 1'b0;
        repeat (220) @(negedge Clk);
        chk("t4_busy", bus.i2c_idle, 0);
        #2 Rst_n = 1'b0;
        #1;
        chk("t4_scl",  bus.i2c_sclk, 1);
        chk("t4_oe",   bus.i2c_sda_oe, 0);
        chk("t4_idle", bus.i2c_idle, 1);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt(24'h340C00, 1'b0, -5, 24'h0, cyc);
        chk_full("t4_after", cyc, 8'h34, 8'h0C, 8'h00);

`ifdef CODEC_I2C_ACK_CHECK_EN
        // 5: slave NACKs the first byte
        nack_idx = 0;
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt(24'h340E4A, 1'b0, -5, 24'h0, cyc);
        chk("t5_len",    (cyc >= LEN_NAK && cyc <= LEN_NAK + 1), 1);
        chk("t5_ackerr", bus.ack_error, 1);
        chk("t5_nbyte",  rx_cnt, 1);
        chk("t5_b0",     rx_byte[0], 8'h34);
        chk("t5_stop",   stop_cnt - p0, 1);
        repeat (20) @(negedge Clk);
        chk("t5_sticky", bus.ack_error, 1);
        nack_idx = -1;
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt(24'h340E4A, 1'b0, -5, 24'h0, cyc);
        chk_full("t5_clear", cyc, 8'h34, 8'h0E, 8'h4A);
`endif

        // 6: back-to-back, strobe on the first idle cycle
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt(24'h340812, 1'b0, -5, 24'h0, cyc);
        chk_full("t6_a", cyc, 8'h34, 8'h08, 8'h12);
        s0 = start_cnt; p0 = stop_cnt;
        run_pkt(24'h340A06, 1'b1, -5, 24'h0, cyc);
        chk_full("t6_b", cyc, 8'h34, 8'h0A, 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
